// File: rtl/present_pkg.sv
// Shared PRESENT definitions: S-box tables, bit-permutation layers, round count and FSM states.
package present_pkg;

  localparam int unsigned NumRounds = 31;

  // Nibble x lives at bits [4*x+3:4*x].
  localparam logic [63:0] SboxTbl    = 64'h21748FE3DA09B65C;
  localparam logic [63:0] InvSboxTbl = 64'hA970364BD21C8FE5;

  typedef enum logic [1:0] {
    StIdle,
    StKeygen,
    StRun,
    StDone
  } fsm_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SboxTbl[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return InvSboxTbl[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) begin
      r[6'(4 * n) +: 4] = sbox(s[6'(4 * n) +: 4]);
    end
    return r;
  endfunction

  function automatic logic [63:0] inv_sbox_layer(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) begin
      r[6'(4 * n) +: 4] = inv_sbox(s[6'(4 * n) +: 4]);
    end
    return r;
  endfunction

  // Bit i moves to 16*(i mod 4) + i/4, which equals 16*i mod 63 with bit 63 fixed.
  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      r[6'(16 * (i % 4) + i / 4)] = s[i];
    end
    return r;
  endfunction

  function automatic logic [63:0] inv_p_layer(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      r[i] = s[6'(16 * (i % 4) + i / 4)];
    end
    return r;
  endfunction

endpackage

// File: rtl/present_keysched.sv
// One PRESENT key-schedule step, forward (K_r -> K_r+1) or inverse (K_r+1 -> K_r) for counter rc.
module present_keysched
  import present_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = 80
) (
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic [4:0]           rc_i,
  input  logic                 inv_i,
  output logic [KEY_WIDTH-1:0] key_o
);

  logic [KEY_WIDTH-1:0] fwd_key;
  logic [KEY_WIDTH-1:0] rev_key;

  if (KEY_WIDTH == 128) begin : gen_k128
    logic [127:0] undo;
    always_comb begin
      fwd_key            = {key_i[66:0], key_i[127:67]};
      fwd_key[127:124]   = sbox(fwd_key[127:124]);
      fwd_key[123:120]   = sbox(fwd_key[123:120]);
      fwd_key[66:62]     = fwd_key[66:62] ^ rc_i;

      undo               = key_i;
      undo[66:62]        = undo[66:62] ^ rc_i;
      undo[127:124]      = inv_sbox(undo[127:124]);
      undo[123:120]      = inv_sbox(undo[123:120]);
      rev_key            = {undo[60:0], undo[127:61]};
    end
  end else begin : gen_k80
    logic [79:0] undo;
    always_comb begin
      fwd_key          = {key_i[18:0], key_i[79:19]};
      fwd_key[79:76]   = sbox(fwd_key[79:76]);
      fwd_key[19:15]   = fwd_key[19:15] ^ rc_i;

      undo             = key_i;
      undo[19:15]      = undo[19:15] ^ rc_i;
      undo[79:76]      = inv_sbox(undo[79:76]);
      rev_key          = {undo[60:0], undo[79:61]};
    end
  end

  assign key_o = inv_i ? rev_key : fwd_key;

endmodule

// File: rtl/present_core.sv
// Iterative PRESENT block cipher, one round per cycle, with optional decryption via key replay.
module present_core
  import present_pkg::*;
#(
  parameter int unsigned KEY_WIDTH  = 80,
  parameter int unsigned DECRYPT_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [63:0]          data_in,
  input  logic [KEY_WIDTH-1:0] key_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          data_out,
  output logic                 busy
);

  if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : gen_bad_key_width
    $error("present_core: KEY_WIDTH must be 80 or 128");
  end

  localparam logic [5:0] FinalRound = 6'(NumRounds + 1);

  fsm_e                 fsm_q, fsm_d;
  logic [63:0]          state_q, state_d;
  logic [63:0]          dout_q, dout_d;
  logic [KEY_WIDTH-1:0] key_q, key_d, ks_key;
  logic [5:0]           round_q, round_d;
  logic                 dec_q, dec_d;
  logic                 mode_eff;
  logic                 ks_inv;
  logic [4:0]           ks_rc;
  logic [63:0]          key_top;

  assign mode_eff = (DECRYPT_EN != 0) && mode;
  assign key_top  = key_q[KEY_WIDTH-1 -: 64];

  // Inverse steps run on the way out of KEYGEN and during every decrypt round; the counter
  // that produced K_r is r-1, so the inverse uses round-1.
  assign ks_inv = (DECRYPT_EN != 0) &&
                  ((fsm_q == StKeygen && round_q == FinalRound) || (fsm_q == StRun && dec_q));
  assign ks_rc  = ks_inv ? 5'(round_q - 6'd1) : round_q[4:0];

  present_keysched #(
    .KEY_WIDTH(KEY_WIDTH)
  ) u_keysched (
    .key_i(key_q),
    .rc_i (ks_rc),
    .inv_i(ks_inv),
    .key_o(ks_key)
  );

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    dec_d   = dec_q;
    dout_d  = dout_q;
    unique case (fsm_q)
      StIdle: begin
        if (in_valid) begin
          state_d = data_in;
          key_d   = key_in;
          round_d = 6'd1;
          dec_d   = mode_eff;
          fsm_d   = mode_eff ? StKeygen : StRun;
        end
      end
      StKeygen: begin
        key_d = ks_key;
        if (round_q == FinalRound) begin
          state_d = state_q ^ key_top;
          round_d = 6'(NumRounds);
          fsm_d   = StRun;
        end else begin
          round_d = round_q + 6'd1;
        end
      end
      StRun: begin
        key_d = ks_key;
        if ((DECRYPT_EN != 0) && dec_q) begin
          state_d = inv_sbox_layer(inv_p_layer(state_q)) ^ key_top;
          round_d = round_q - 6'd1;
          if (round_q == 6'd1) begin
            dout_d = state_d;
            fsm_d  = StDone;
          end
        end else if (round_q == FinalRound) begin
          // Extra cycle for the final whitening with K32.
          dout_d = state_q ^ key_top;
          fsm_d  = StDone;
        end else begin
          state_d = p_layer(sbox_layer(state_q ^ key_top));
          round_d = round_q + 6'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          fsm_d = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      dout_q  <= dout_d;
    end
  end

  assign in_ready  = (fsm_q == StIdle);
  assign out_valid = (fsm_q == StDone);
  assign busy      = (fsm_q != StIdle);
  assign data_out  = dout_q;

endmodule

// File: doc/present_core.md
PRESENT_CORE -- requirements
Module: present_core

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 80, key length; legal values 80 or 128, any other value is an elaboration error.
REQ-002 SHALL have parameter DECRYPT_EN, default 1; when 0, decrypt logic is omitted and mode is ignored (treated as 0).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  core can accept a request.
REQ-007 SHALL have port mode  input  1  0 = encrypt, 1 = decrypt; sampled on accept.
REQ-008 SHALL have port data_in  input  64  plaintext or ciphertext; sampled on accept.
REQ-009 SHALL have port key_in  input  KEY_WIDTH  cipher key; sampled on accept.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port data_out  output  64  result block.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement PRESENT, 31 rounds, with the standard 4-bit S-box and bit permutation P(i) = 16*i mod 63 for i < 63, and P(63) = 63.
REQ-015 SHALL use the following FSM: IDLE, KEYGEN, RUN, DONE.
REQ-016 SHALL raise in_ready only in IDLE; accept occurs on in_valid & in_ready.
REQ-017 SHALL, on an encrypt accept, load state <= data_in, key <= key_in, round <= 1, and go to RUN.
REQ-018 SHALL, in each RUN encrypt cycle, compute state <= P(S(state ^ key[top 64])), advance the key schedule with round counter value round, and increment round.
REQ-019 SHALL, after the round-31 update, go to DONE and set data_out = state ^ K32; out_valid SHALL rise exactly 32 cycles after the accept edge.
REQ-020 SHALL, on a decrypt accept (DECRYPT_EN = 1), go to KEYGEN and run the forward key schedule for 31 cycles to obtain K32; the state register holds data_in.
REQ-021 SHALL, on leaving KEYGEN, set state <= state ^ K32, step the key register back once to K31, and enter RUN with round = 31.
REQ-022 SHALL, in each RUN decrypt cycle, compute state <= S^-1(P^-1(state)) ^ K_round, apply the inverse key schedule, and decrement round.
REQ-023 SHALL, after the K1 step of a decrypt, go to DONE; decrypt out_valid SHALL rise 63 cycles after the accept edge.
REQ-024 SHALL define the key schedule as follows: 80-bit = rotate left 61, S-box on bits [79:76], XOR round counter into [19:15]; 128-bit = rotate left 61, S-box on [127:124] and [123:120], XOR counter into [66:62]; the inverse schedule is the exact reverse of these steps.
REQ-025 SHALL, in DONE, hold out_valid and data_out stable until out_ready; on out_valid & out_ready it SHALL go to IDLE, with in_ready high the next cycle (no same-cycle re-accept).
REQ-026 SHALL ignore in_valid while busy; the inputs data_in, key_in and mode need only be stable on the accept cycle.
REQ-027 SHALL keep data_out at the last result while in IDLE.

Reset
REQ-028 SHALL, on rst_n low, put the FSM in IDLE, and clear state, key and round to 0, out_valid to 0, busy to 0, and data_out to 0; in_ready SHALL be 1 once reset is released.
REQ-029 SHALL, when reset asserts mid-operation, discard the operation with no partial out_valid.

Structure
REQ-030 SHALL place the following in the shared package present_pkg: the S-box and inverse S-box tables, the pLayer and inverse pLayer functions, the round count constant (31), and FSM state typedef.
REQ-031 SHALL contain exactly one sub-module, present_keysched (forward/inverse step, parametrised by KEY_WIDTH).

Verification
REQ-032 SHALL cover: KEY_WIDTH=80, encrypt, pt=0, key=0 -> data_out=5579C1387B228445 with out_valid at cycle 32.
REQ-033 SHALL cover: KEY_WIDTH=80, encrypt, pt=FFFFFFFFFFFFFFFF, key all F -> 3333DCD3213210D2; then decrypt of that result with the same key -> FFFFFFFFFFFFFFFF at cycle 63.
REQ-034 SHALL cover: KEY_WIDTH=128, encrypt, pt=0, key=0 -> 96DB702A2E6900AF.
REQ-035 SHALL cover: out_ready held low for 10 cycles in DONE -> out_valid and data_out stable throughout; in_valid pulsed while busy -> no accept, result unchanged.
REQ-036 SHALL cover: rst_n asserted at round 15 -> out_valid=0 and in_ready=1 after release; the next encryption of pt=0, key all F -> E72C46C0F5945049.
